// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register plus writeback mux for the MIPS
// datapath. Drives the register file write port, extracts and extends
// sub-word loads, blocks writes to $0 and misaligned loads, and counts
// retired instructions.
module writeback_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_RegWrite,
    input  logic [1:0]       in_wb_sel,
    input  logic [2:0]       in_load_type,
    input  logic [4:0]       in_dest,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_rdata,
    input  logic [31:0]      in_pc_plus4,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    output logic             RegWrite,
    output logic [CNT_W-1:0] retired_count,
    output logic             misalign_err
);

    // Writeback source select
    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    // Load type encodings; 101-111 behave as lw
    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    // Stage register
    logic        valid_q,     valid_d;
    logic        regwrite_q,  regwrite_d;
    logic [1:0]  wb_sel_q,    wb_sel_d;
    logic [2:0]  load_type_q, load_type_d;
    logic [4:0]  dest_q,      dest_d;
    logic [31:0] alu_q,       alu_d;
    logic [31:0] rdata_q,     rdata_d;
    logic [31:0] pc4_q,       pc4_d;

    // Bookkeeping
    logic [CNT_W-1:0] retired_count_q, retired_count_d;
    logic             misalign_err_q,  misalign_err_d;

    // Datapath intermediates
    logic [1:0]  byte_off;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;
    logic        is_half;
    logic        misaligned;
    logic [31:0] wb_val;

    // Stage next-state: flush drops the valid bit, stall holds, else capture.
    // Payload fields are simply held on flush since they are don't-care once
    // valid is low.
    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        wb_sel_d    = wb_sel_q;
        load_type_d = load_type_q;
        dest_d      = dest_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        pc4_d       = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d     = in_valid;
            regwrite_d  = in_RegWrite;
            wb_sel_d    = in_wb_sel;
            load_type_d = in_load_type;
            dest_d      = in_dest;
            alu_d       = in_alu_result;
            rdata_d     = in_mem_rdata;
            pc4_d       = in_pc_plus4;
        end
    end

    // Big-endian sub-word selection: byte offset 0 is the most significant byte
    always_comb begin
        byte_off = alu_q[1:0];
        case (byte_off)
            2'd0:    load_byte = rdata_q[31:24];
            2'd1:    load_byte = rdata_q[23:16];
            2'd2:    load_byte = rdata_q[15:8];
            default: load_byte = rdata_q[7:0];
        endcase
        // Only offset bit 1 picks the half; odd offsets are flagged misaligned
        load_half = byte_off[1] ? rdata_q[15:0] : rdata_q[31:16];
    end

    // Sign/zero extension according to load type
    always_comb begin
        case (load_type_q)
            LT_LB:   load_val = {{24{load_byte[7]}}, load_byte};
            LT_LBU:  load_val = {24'h0, load_byte};
            LT_LH:   load_val = {{16{load_half[15]}}, load_half};
            LT_LHU:  load_val = {16'h0, load_half};
            default: load_val = rdata_q;
        endcase
    end

    // Alignment check for the resident load
    always_comb begin
        is_half    = (load_type_q == LT_LH) || (load_type_q == LT_LHU);
        misaligned = 1'b0;
        if (wb_sel_q == SEL_LOAD) begin
            if (is_half)
                misaligned = byte_off[0];
            else if (load_type_q == LT_LW || load_type_q > LT_LHU)
                misaligned = (byte_off != 2'd0);
        end
    end

    // Writeback source mux; bubbles present zero data
    always_comb begin
        case (wb_sel_q)
            SEL_LOAD: wb_val = load_val;
            SEL_LINK: wb_val = pc4_q;
            default:  wb_val = alu_q;   // SEL_ALU and the reserved code
        endcase
        if (!valid_q)
            wb_val = 32'h0;
    end

    // Retire counter and sticky misalignment flag. A flushed-out instruction
    // still leaves the stage, so only stall and misalignment hold the count.
    always_comb begin
        retired_count_d = retired_count_q;
        if (valid_q && !stall && !misaligned)
            retired_count_d = retired_count_q + CNT_W'(1);
        misalign_err_d = misalign_err_q | (valid_q & misaligned);
    end

    // State update; synchronous reset has top priority
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= 1'b0;
            regwrite_q      <= 1'b0;
            wb_sel_q        <= 2'b00;
            load_type_q     <= 3'b000;
            dest_q          <= 5'd0;
            alu_q           <= 32'h0;
            rdata_q         <= 32'h0;
            pc4_q           <= 32'h0;
            retired_count_q <= '0;
            misalign_err_q  <= 1'b0;
        end else begin
            valid_q         <= valid_d;
            regwrite_q      <= regwrite_d;
            wb_sel_q        <= wb_sel_d;
            load_type_q     <= load_type_d;
            dest_q          <= dest_d;
            alu_q           <= alu_d;
            rdata_q         <= rdata_d;
            pc4_q           <= pc4_d;
            retired_count_q <= retired_count_d;
            misalign_err_q  <= misalign_err_d;
        end
    end

    // Register file write port, straight from the stage register
    assign write_reg     = dest_q;
    assign write_data    = wb_val;
    assign RegWrite      = valid_q & regwrite_q & (dest_q != 5'd0) & ~misaligned;
    assign retired_count = retired_count_q;
    assign misalign_err  = misalign_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage. A behavioural model of the
// resident instruction predicts every output; a second instance with a
// 4-bit counter exercises counter wrap-around.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_RegWrite;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_load_type;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4;

    logic [4:0]  write_reg,  wr_w;
    logic [31:0] write_data, wd_w;
    logic        RegWrite,   we_w;
    logic [31:0] retired_count;
    logic [3:0]  cnt_w;
    logic        misalign_err, err_w;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    writeback_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_wb_sel(in_wb_sel),
        .in_load_type(in_load_type), .in_dest(in_dest),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc_plus4(in_pc_plus4),
        .write_reg(write_reg), .write_data(write_data), .RegWrite(RegWrite),
        .retired_count(retired_count), .misalign_err(misalign_err)
    );

    writeback_stage #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_wb_sel(in_wb_sel),
        .in_load_type(in_load_type), .in_dest(in_dest),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc_plus4(in_pc_plus4),
        .write_reg(wr_w), .write_data(wd_w), .RegWrite(we_w),
        .retired_count(cnt_w), .misalign_err(err_w)
    );

    // ---------------- reference model ----------------
    logic        m_valid, m_rw;
    logic [1:0]  m_sel;
    logic [2:0]  m_lt;
    logic [4:0]  m_dest;
    logic [31:0] m_alu, m_rdata, m_pc4;
    int unsigned m_cnt;
    logic        m_err;

    function automatic bit m_misaligned();
        int a = int'(m_alu % 4);
        if (m_sel != 2'b01) return 0;
        if (m_lt == 3 || m_lt == 4) return (a % 2) == 1;
        if (m_lt == 1 || m_lt == 2) return 0;
        return a != 0;
    endfunction

    function automatic logic [31:0] m_load();
        int unsigned a = m_alu % 4;
        logic [31:0] b = (m_rdata >> (24 - 8 * a)) & 32'hFF;
        logic [31:0] h = (a < 2) ? (m_rdata >> 16) : (m_rdata & 32'hFFFF);
        case (m_lt)
            3'd1:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return h;
            default: return m_rdata;
        endcase
    endfunction

    function automatic logic [31:0] m_data();
        if (!m_valid) return 0;
        if (m_sel == 2'b01) return m_load();
        if (m_sel == 2'b10) return m_pc4;
        return m_alu;
    endfunction

    function automatic logic m_we();
        return m_valid && m_rw && m_dest != 0 && !m_misaligned();
    endfunction

    // Expected {reg, data, we, count, err, narrow count}
    function automatic logic [74:0] exp_vec();
        logic [31:0] c = m_cnt;
        return {m_dest, m_data(), m_we(), c, m_err, c[3:0]};
    endfunction

    function automatic logic [74:0] act_vec();
        return {write_reg, write_data, RegWrite, retired_count, misalign_err, cnt_w};
    endfunction

    task automatic model_edge();
        if (rst) begin
            {m_valid, m_rw, m_sel, m_lt, m_dest} = '0;
            {m_alu, m_rdata, m_pc4} = '0;
            m_cnt = 0;
            m_err = 0;
        end else begin
            if (m_valid && !stall && !m_misaligned()) m_cnt = m_cnt + 1;
            if (m_valid && m_misaligned()) m_err = 1;
            if (flush) m_valid = 0;
            else if (!stall) begin
                m_valid = in_valid; m_rw = in_RegWrite; m_sel = in_wb_sel;
                m_lt = in_load_type; m_dest = in_dest; m_alu = in_alu_result;
                m_rdata = in_mem_rdata; m_pc4 = in_pc_plus4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [4:0] d,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [31:0] pc4);
        in_valid = v; in_RegWrite = rw; in_wb_sel = sel; in_load_type = lt;
        in_dest = d; in_alu_result = alu; in_mem_rdata = rd; in_pc_plus4 = pc4;
    endtask

    task automatic do_reset();
        rst = 1; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({write_reg, write_data, RegWrite, retired_count, misalign_err, cnt_w} !== 75'd0) begin
            errors++;
            $display("FAIL reset: got %h required 0", act_vec());
        end
    endtask

    task automatic test_alu();
        do_reset();
        drive(1, 1, 2'b00, 0, 5, 32'h1234_5678, 32'hDEAD_BEEF, 32'h4);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({write_reg, write_data, RegWrite, retired_count} !== {5'd5, 32'h1234_5678, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL alu_wb: got reg=%0d data=%h we=%b cnt=%0d", write_reg, write_data, RegWrite, retired_count);
        end
        tick();
        checks++;
        if (retired_count !== 32'd1) begin
            errors++;
            $display("FAIL alu_retire: got %0d required 1", retired_count);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lt  [7] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [1:0]  off [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
        logic [31:0] exp [7] = '{32'hFFFF_FF80, 32'hFFFF_FFFF, 32'h0000_007F,
                                 32'h0000_0001, 32'h0000_0080, 32'h0000_7F01,
                                 32'h0000_80FF};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 2'b01, lt[i], 9, 32'h1000_0000 | 32'(off[i]), 32'h80FF_7F01, 0);
            tick();
            checks++;
            if (write_data !== exp[i] || RegWrite !== 1'b1 || act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL load_%0d: got data=%h we=%b required data=%h we=1", i, write_data, RegWrite, exp[i]);
            end
        end
    endtask

    task automatic test_dest_zero();
        logic [31:0] c0;
        do_reset();
        c0 = retired_count;
        drive(1, 1, 2'b00, 0, 0, 32'hAAAA_5555, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL dest_zero_we: got %b required 0", RegWrite);
        end
        tick();
        checks++;
        if (retired_count !== c0 + 1) begin
            errors++;
            $display("FAIL dest_zero_cnt: got %0d required %0d", retired_count, c0 + 1);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        drive(1, 1, 2'b01, 3'd0, 7, 32'h1000_0002, 32'h1111_2222, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (RegWrite !== 1'b0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_first: got we=%b err=%b required we=0 err=0", RegWrite, misalign_err);
        end
        tick();
        tick();
        checks++;
        if (misalign_err !== 1'b1 || retired_count !== 32'd0) begin
            errors++;
            $display("FAIL misalign_sticky: got err=%b cnt=%0d required err=1 cnt=0", misalign_err, retired_count);
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clear: got %b required 0", misalign_err);
        end
    endtask

    task automatic test_stall_jal();
        logic [31:0] c0;
        do_reset();
        drive(1, 1, 2'b10, 0, 31, 32'h5, 32'h6, 32'h0040_0008);
        tick();
        c0 = retired_count;
        stall = 1;
        drive(1, 1, 2'b00, 0, 3, 32'hFFFF_0000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({write_reg, write_data, RegWrite, retired_count} !== {5'd31, 32'h0040_0008, 1'b1, c0}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got reg=%0d data=%h we=%b cnt=%0d", i, write_reg, write_data, RegWrite, retired_count);
            end
        end
        stall = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (retired_count !== c0 + 1) begin
            errors++;
            $display("FAIL stall_release_cnt: got %0d required %0d", retired_count, c0 + 1);
        end
    endtask

    task automatic test_flush_stall_wrap();
        do_reset();
        drive(1, 1, 2'b00, 0, 4, 32'h77, 0, 0);
        tick();
        flush = 1; stall = 1;
        tick();
        flush = 0; stall = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (RegWrite !== 1'b0 || write_data !== 32'h0 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL flush_stall: got we=%b data=%h required we=0 data=0", RegWrite, write_data);
        end
        // 16 retirements wrap the 4-bit counter back to zero
        do_reset();
        drive(1, 1, 2'b00, 0, 2, 32'h1, 0, 0);
        for (int i = 0; i < 16; i++) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (cnt_w !== 4'd0 || retired_count !== 32'd16) begin
            errors++;
            $display("FAIL count_wrap: got narrow=%0d wide=%0d required 0 and 16", cnt_w, retired_count);
        end
    endtask

    task automatic test_rst_mid_stall();
        do_reset();
        drive(1, 1, 2'b00, 0, 12, 32'hCAFE, 0, 0);
        tick();
        tick();
        stall = 1;
        tick();
        rst = 1;
        tick();
        rst = 0; stall = 0;
        checks++;
        if ({write_reg, write_data, RegWrite, retired_count, misalign_err} !== 71'd0) begin
            errors++;
            $display("FAIL rst_mid_stall: got reg=%0d data=%h we=%b cnt=%0d", write_reg, write_data, RegWrite, retired_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom, $urandom, $urandom);
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d: got %h required %h", i, act_vec(), exp_vec());
            end
        end
        rst = 0; flush = 0; stall = 0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_dest_zero();
        test_misalign();
        test_stall_jal();
        test_flush_stall_wrap();
        test_rst_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
